// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// default data-memory size and the alignment helper.
package lsu_pkg;

  localparam int LSU_MEM_BYTES = 4096;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // True when the access cannot be served: illegal size or misaligned address.
  function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/be_lane_unit.sv
// Big-endian lane logic: extracts and extends a load result from a memory
// word, and merges store data into the addressed lane of a memory word.
module be_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  lsu_size_e   size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed lane (offset 0 is the most significant byte) and extend it.
  always_comb begin
    lane_byte = 8'h00;
    case (offset)
      2'd0: lane_byte = word[31:24];
      2'd1: lane_byte = word[23:16];
      2'd2: lane_byte = word[15:8];
      2'd3: lane_byte = word[7:0];
    endcase
    lane_half = offset[1] ? word[15:0] : word[31:16];
    rdata = word;
    case (size)
      SIZE_BYTE: rdata = sign_ext ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
      SIZE_HALF: rdata = sign_ext ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
      default:   rdata = word;
    endcase
  end

  // Replace only the addressed lane; untouched lanes keep the memory word.
  always_comb begin
    merged = word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0: merged[31:24] = wdata[7:0];
          2'd1: merged[23:16] = wdata[7:0];
          2'd2: merged[15:8]  = wdata[7:0];
          2'd3: merged[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged[15:0] = wdata[15:0];
        else           merged[31:16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from the datapath, drives a
// word-wide big-endian data memory (read-modify-write for sub-word stores)
// and returns a single-cycle response with extended load data or an error.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only when idle and out of reset, and
// req_valid is ignored otherwise. The response is a one-cycle rsp_valid
// pulse with rsp_err/rsp_rdata valid in that cycle; there is no back-pressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dm_cs,
  output logic        dm_wr,
  output logic        dm_rd,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic [1:0]  state_dbg
);

  lsu_state_e  state;
  logic        op_wr;
  lsu_size_e   op_size;
  logic        op_signed;
  logic [1:0]  op_offset;
  logic [31:0] op_wdata;
  logic        req_err;
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  assign req_ready = reset && (state == ST_IDLE);
  assign state_dbg = state;

  // Classify the incoming request as rejected before it is accepted.
  always_comb begin
    req_err = size_illegal(req_size, req_addr[1:0]) || (req_addr >= 32'(MEM_BYTES));
  end

  be_lane_unit u_lane (
    .word     (dm_dout),
    .size     (op_size),
    .offset   (op_offset),
    .sign_ext (op_signed),
    .wdata    (op_wdata),
    .rdata    (lane_rdata),
    .merged   (lane_merged)
  );

  // Request FSM with registered memory controls and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_wr     <= 1'b0;
      op_size   <= SIZE_BYTE;
      op_signed <= 1'b0;
      op_offset <= 2'b00;
      op_wdata  <= 32'h0;
      dm_cs     <= 1'b0;
      dm_wr     <= 1'b0;
      dm_rd     <= 1'b0;
      dm_addr   <= 32'h0;
      dm_din    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (req_valid) begin
            op_wr     <= req_wr;
            op_size   <= lsu_size_e'(req_size);
            op_signed <= req_signed;
            op_offset <= req_addr[1:0];
            op_wdata  <= req_wdata;
            dm_addr   <= {req_addr[31:2], 2'b00};
            if (req_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (req_wr && (req_size == SIZE_WORD)) begin
              state  <= ST_WR;
              dm_cs  <= 1'b1;
              dm_wr  <= 1'b1;
              dm_din <= req_wdata;
            end else begin
              state <= ST_RD;
              dm_cs <= 1'b1;
              dm_rd <= 1'b1;
            end
          end
        end
        ST_RD: begin
          dm_rd <= 1'b0;
          if (op_wr) begin
            state  <= ST_WR;
            dm_wr  <= 1'b1;
            dm_din <= lane_merged;
          end else begin
            state     <= ST_RESP;
            dm_cs     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= lane_rdata;
          end
        end
        ST_WR: begin
          state     <= ST_RESP;
          dm_cs     <= 1'b0;
          dm_wr     <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, byte-array reference model,
// directed scenarios and randomized requests.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEMB = 4096;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dm_cs;
  logic        dm_wr;
  logic        dm_rd;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_words [MEMB/4];
  logic [7:0]  ref_mem   [MEMB];

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          rd_n;
    int          wr_n;
    int          cs_n;
    int          bad_ctl;
    logic [31:0] din;
    logic        rdy_ok;
    logic        one_pulse;
    logic        held;
  } obs_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [31:0] din;
  } exp_t;

  load_store_unit #(.MEM_BYTES(MEMB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dm_cs      (dm_cs),
    .dm_wr      (dm_wr),
    .dm_rd      (dm_rd),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_dout    (dm_dout),
    .state_dbg  (state_dbg)
  );

  // Clock and data memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = (dm_cs && dm_rd) ? mem_words[dm_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (dm_cs && dm_wr) mem_words[dm_addr[11:2]] <= dm_din;
  end

  // Reference model: byte-addressed big-endian memory, expectations from the access rules.
  function automatic exp_t model(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int nb;
    logic [31:0] v;
    logic [31:0] a;
    e.rdata = 32'h0; e.din = 32'h0; e.rd_n = 0; e.wr_n = 0; e.lat = 1;
    e.err = (size == 2'b11) || (addr >= MEMB) || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00);
    if (e.err) return e;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (!wr) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[int'(addr) + i]);
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
      e.rdata = v; e.lat = 2; e.rd_n = 1;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*(nb-1-i) +: 8];
      a = addr & ~32'h3;
      e.din = {ref_mem[int'(a)], ref_mem[int'(a)+1], ref_mem[int'(a)+2], ref_mem[int'(a)+3]};
      e.wr_n = 1;
      e.rd_n = (nb < 4) ? 1 : 0;
      e.lat  = (nb < 4) ? 3 : 2;
    end
    return e;
  endfunction

  // Driver/monitor: issue one request from idle and record what the DUT does until one cycle after the response.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
    o.lat = 0; o.rd_n = 0; o.wr_n = 0; o.cs_n = 0; o.bad_ctl = 0; o.din = 32'h0;
    @(negedge clk);
    o.rdy_ok   = req_ready;
    req_valid  = 1'b1;
    req_wr     = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    while (o.lat < 10) begin
      @(negedge clk);
      req_valid = 1'b0;
      o.lat++;
      if (dm_cs) o.cs_n++;
      if (dm_cs && dm_rd) o.rd_n++;
      if (dm_cs && dm_wr) begin o.wr_n++; o.din = dm_din; end
      if (dm_rd && dm_wr) o.bad_ctl++;
      if (dm_cs && dm_addr != {addr[31:2], 2'b00}) o.bad_ctl++;
      if (rsp_valid && dm_cs) o.bad_ctl++;
      if (req_ready && !rsp_valid) o.bad_ctl++;
      if (rsp_valid) break;
    end
    o.err   = rsp_err;
    o.rdata = rsp_rdata;
    @(negedge clk);
    o.one_pulse = !rsp_valid && req_ready && !dm_cs;
    o.held      = (rsp_rdata === o.rdata);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({dm_cs, dm_wr, dm_rd, rsp_valid, rsp_err, req_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl: got cs/wr/rd/rv/err/rdy=%b want 000000",
               {dm_cs, dm_wr, dm_rd, rsp_valid, rsp_err, req_ready});
    end
    total++;
    if ({dm_addr, dm_din, rsp_rdata} !== 96'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h din=%h rdata=%h want zeros", dm_addr, dm_din, rsp_rdata);
    end
    total++;
    if (state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
  endtask

  task automatic test_store_load_word();
    obs_t o;
    exp_t e;
    logic [31:0] want [3];
    logic [1:0]  sz   [3];
    logic [31:0] ad   [3];
    want[0] = 32'h00000012; sz[0] = 2'b00; ad[0] = 32'h10;
    want[1] = 32'h00000078; sz[1] = 2'b00; ad[1] = 32'h13;
    want[2] = 32'h00005678; sz[2] = 2'b01; ad[2] = 32'h12;
    e = model(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, o);
    total++;
    if (o.lat !== 2 || o.rd_n !== 0 || o.wr_n !== 1 || o.din !== 32'h12345678 || o.err !== 1'b0) begin
      bad++;
      $display("FAIL word_store: got lat=%0d rd=%0d wr=%0d din=%h err=%b want 2/0/1/12345678/0",
               o.lat, o.rd_n, o.wr_n, o.din, o.err);
    end
    for (int i = 0; i < 3; i++) begin
      e = model(1'b0, sz[i], 1'b0, ad[i], 32'h0);
      issue(1'b0, sz[i], 1'b0, ad[i], 32'h0, o);
      total++;
      if (o.rdata !== want[i] || o.rdata !== e.rdata || o.lat !== 2 || o.rd_n !== 1 || o.wr_n !== 0) begin
        bad++;
        $display("FAIL load_sub_%0d: got rdata=%h lat=%0d rd=%0d wr=%0d want %h/2/1/0",
                 i, o.rdata, o.lat, o.rd_n, o.wr_n, want[i]);
      end
    end
  endtask

  task automatic test_rmw_byte();
    obs_t o;
    exp_t e;
    e = model(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, o);
    total++;
    if (o.rd_n !== 1 || o.wr_n !== 1 || o.din !== 32'h12AB5678 || o.lat !== 3 || o.din !== e.din) begin
      bad++;
      $display("FAIL rmw_byte: got rd=%0d wr=%0d din=%h lat=%0d want 1/1/12ab5678/3",
               o.rd_n, o.wr_n, o.din, o.lat);
    end
    total++;
    if (o.rdata !== 32'h0) begin
      bad++;
      $display("FAIL rmw_rdata_zero: got %h want 0", o.rdata);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, o);
    total++;
    if (o.rdata !== 32'h12AB5678) begin
      bad++;
      $display("FAIL rmw_readback: got %h want 12ab5678", o.rdata);
    end
  endtask

  task automatic test_sign_ext();
    obs_t o;
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, o);
    total++;
    if (o.rdata !== 32'hFFFFFFAB) begin
      bad++;
      $display("FAIL load_signed: got %h want ffffffab", o.rdata);
    end
    total++;
    if (o.held !== 1'b1 || o.one_pulse !== 1'b1) begin
      bad++;
      $display("FAIL rsp_hold_pulse: got held=%b pulse=%b want 1/1", o.held, o.one_pulse);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, o);
    total++;
    if (o.rdata !== 32'h000000AB) begin
      bad++;
      $display("FAIL load_unsigned: got %h want 000000ab", o.rdata);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic        wrs [5];
    logic [1:0]  szs [5];
    logic [31:0] ads [5];
    wrs[0] = 1'b0; szs[0] = 2'b10; ads[0] = 32'h12;
    wrs[1] = 1'b0; szs[1] = 2'b01; ads[1] = 32'h11;
    wrs[2] = 1'b0; szs[2] = 2'b10; ads[2] = 32'h1000;
    wrs[3] = 1'b1; szs[3] = 2'b00; ads[3] = 32'h1000;
    wrs[4] = 1'b1; szs[4] = 2'b11; ads[4] = 32'h20;
    for (int i = 0; i < 5; i++) begin
      issue(wrs[i], szs[i], 1'b0, ads[i], 32'hDEADBEEF, o);
      total++;
      if (o.err !== 1'b1 || o.lat !== 1 || o.cs_n !== 0 || o.rdata !== 32'h0 || o.one_pulse !== 1'b1) begin
        bad++;
        $display("FAIL error_%0d: got err=%b lat=%0d cs=%0d rdata=%h pulse=%b want 1/1/0/0/1",
                 i, o.err, o.lat, o.cs_n, o.rdata, o.one_pulse);
      end
    end
  endtask

  task automatic test_reset_in_wr();
    obs_t o;
    exp_t e;
    logic saw_wr;
    e = model(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, o);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h00001111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    saw_wr = dm_cs && dm_wr;
    total++;
    if (saw_wr !== 1'b1) begin
      bad++;
      $display("FAIL rst_wr_reach: got cs&wr=%b want 1", saw_wr);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (dm_cs !== 1'b0 || dm_wr !== 1'b0) begin
      bad++;
      $display("FAIL rst_wr_async: got cs=%b wr=%b want 0/0", dm_cs, dm_wr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    e = model(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, o);
    total++;
    if (o.rdata !== 32'hCAFEF00D || o.rdata !== e.rdata) begin
      bad++;
      $display("FAIL rst_wr_mem: got %h want cafef00d", o.rdata);
    end
  endtask

  task automatic test_back_to_back();
    int acc_at [2];
    int rsp_at [2];
    logic [31:0] rsp_d [2];
    int n_acc, n_rsp, rdy_busy;
    exp_t e;
    n_acc = 0; n_rsp = 0; rdy_busy = 0;
    acc_at[0] = -1; acc_at[1] = -1; rsp_at[0] = -1; rsp_at[1] = -1;
    rsp_d[0] = 32'h0; rsp_d[1] = 32'h0;
    e = model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid && n_rsp < 2) begin rsp_at[n_rsp] = i; rsp_d[n_rsp] = rsp_rdata; n_rsp++; end
      if (rsp_valid && req_ready) rdy_busy++;
      if (req_ready && req_valid && n_acc < 2) begin acc_at[n_acc] = i; n_acc++; end
      @(posedge clk);
      @(negedge clk);
      if (n_acc == 2) req_valid = 1'b0;
    end
    total++;
    if (n_acc !== 2 || n_rsp !== 2 || acc_at[1] !== rsp_at[0] + 1 || rsp_at[0] - acc_at[0] !== 2) begin
      bad++;
      $display("FAIL b2b_timing: got acc=%0d,%0d rsp=%0d,%0d want second accept one after first rsp",
               acc_at[0], acc_at[1], rsp_at[0], rsp_at[1]);
    end
    total++;
    if (rdy_busy !== 0 || rsp_d[0] !== e.rdata || rsp_d[1] !== e.rdata) begin
      bad++;
      $display("FAIL b2b_data: got busy_rdy=%0d d=%h,%h want 0/%h", rdy_busy, rsp_d[0], rsp_d[1], e.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic        wr, sgn;
    logic [1:0]  sz;
    logic [31:0] ad, wd;
    for (int n = 0; n < 60; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      wd  = $urandom;
      case ($urandom_range(0, 7))
        0:       ad = 32'($urandom_range(4088, 4200));
        1:       ad = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        default: ad = 32'($urandom_range(0, 63));
      endcase
      e = model(wr, sz, sgn, ad, wd);
      issue(wr, sz, sgn, ad, wd, o);
      total++;
      if (o.err !== e.err || o.rdata !== e.rdata || o.lat !== e.lat) begin
        bad++;
        $display("FAIL rand_rsp n=%0d wr=%b sz=%0d a=%h: got err=%b d=%h lat=%0d want %b/%h/%0d",
                 n, wr, sz, ad, o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
      total++;
      if (o.rd_n !== e.rd_n || o.wr_n !== e.wr_n || o.cs_n !== e.rd_n + e.wr_n || o.din !== e.din) begin
        bad++;
        $display("FAIL rand_mem n=%0d: got rd=%0d wr=%0d cs=%0d din=%h want %0d/%0d/%0d/%h",
                 n, o.rd_n, o.wr_n, o.cs_n, o.din, e.rd_n, e.wr_n, e.rd_n + e.wr_n, e.din);
      end
      total++;
      if (o.bad_ctl !== 0 || o.rdy_ok !== 1'b1 || o.one_pulse !== 1'b1 || o.held !== 1'b1) begin
        bad++;
        $display("FAIL rand_proto n=%0d: got badctl=%0d rdy=%b pulse=%b held=%b want 0/1/1/1",
                 n, o.bad_ctl, o.rdy_ok, o.one_pulse, o.held);
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    for (int i = 0; i < MEMB/4; i++) mem_words[i] = 32'h0;
    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'h0;
    test_reset();
    test_store_load_word();
    test_rmw_byte();
    test_sign_ext();
    test_errors();
    test_reset_in_wr();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
